// File: rtl/gumnut_dp_pkg.sv
// Shared types for the parametrised Gumnut execution datapath.
//   alu_op_t  : ALU operation encoding carried on alu_op_c
//   wb_sel_t  : register-file writeback source carried on reg_mux_c
//   port_st_t : port-output handshake state
package gumnut_dp_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDC = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBC = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_MASK = 4'd7,
    ALU_SHL  = 4'd8,
    ALU_SHR  = 4'd9,
    ALU_ROL  = 4'd10,
    ALU_ROR  = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_RES  = 2'b00,
    WB_DATA = 2'b01,
    WB_PORT = 2'b10,
    WB_ZERO = 2'b11
  } wb_sel_t;

  typedef enum logic {
    P_IDLE = 1'b0,
    P_PEND = 1'b1
  } port_st_t;

endpackage

// File: rtl/gumnut_datapath_gen_if.sv
// Control/data bus between the Gumnut control unit (master) and the
// execution datapath (slave). Parameters DW/NREG must match the datapath.
//   master drives: clk_en_i, register selects, immed/count, ALU/flag/writeback
//                  strobes, memory/port read data, port_we_c, port_ack_i
//   slave drives : rs2_o, alu_res_o, carry_o, zero_o, port_adr_o/dat_o,
//                  port_stb_o, port_busy_o
interface gumnut_datapath_gen_if #(
  parameter int DW   = 8,
  parameter int NREG = 8
);
  localparam int RAW = $clog2(NREG);
  localparam int CW  = $clog2(DW);

  logic           clk_en_i;
  logic [RAW-1:0] rs_sel_i;
  logic [RAW-1:0] rs2_sel_i;
  logic [RAW-1:0] rd_sel_i;
  logic [7:0]     immed_i;
  logic [CW-1:0]  count_i;
  logic [3:0]     alu_op_c;
  logic           op2_c;
  logic           alu_en_c;
  logic           alu_fr_c;
  logic           reg_wr_c;
  logic [1:0]     reg_mux_c;
  logic [DW-1:0]  data_dat_i;
  logic [DW-1:0]  port_dat_i;
  logic           int_save_c;
  logic           int_rest_c;
  logic           port_we_c;
  logic           port_ack_i;

  logic [DW-1:0]  rs2_o;
  logic [DW-1:0]  alu_res_o;
  logic           carry_o;
  logic           zero_o;
  logic [DW-1:0]  port_adr_o;
  logic [DW-1:0]  port_dat_o;
  logic           port_stb_o;
  logic           port_busy_o;

  modport master (
    output clk_en_i, rs_sel_i, rs2_sel_i, rd_sel_i, immed_i, count_i,
           alu_op_c, op2_c, alu_en_c, alu_fr_c, reg_wr_c, reg_mux_c,
           data_dat_i, port_dat_i, int_save_c, int_rest_c, port_we_c,
           port_ack_i,
    input  rs2_o, alu_res_o, carry_o, zero_o, port_adr_o, port_dat_o,
           port_stb_o, port_busy_o
  );

  modport slave (
    input  clk_en_i, rs_sel_i, rs2_sel_i, rd_sel_i, immed_i, count_i,
           alu_op_c, op2_c, alu_en_c, alu_fr_c, reg_wr_c, reg_mux_c,
           data_dat_i, port_dat_i, int_save_c, int_rest_c, port_we_c,
           port_ack_i,
    output rs2_o, alu_res_o, carry_o, zero_o, port_adr_o, port_dat_o,
           port_stb_o, port_busy_o
  );
endinterface

// File: rtl/gumnut_alu_gen.sv
// Purely combinational Gumnut ALU.
//   a, b : operands (a = rs value, b = rs2 value or zero-extended immediate)
//   cnt  : shift/rotate count
//   op   : operation
//   cin  : carry-in for ADDC/SUBC (registered carry flag)
//   res, carry, zero : result and flag candidates
module gumnut_alu_gen
  import gumnut_dp_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = $clog2(DW)
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [CW-1:0] cnt,
  input  alu_op_t       op,
  input  logic          cin,
  output logic [DW-1:0] res,
  output logic          carry,
  output logic          zero
);

  logic [DW:0]     sum;
  logic [DW:0]     shl;
  logic [DW:0]     shr;
  logic [2*DW-1:0] rol;
  logic [2*DW-1:0] ror;

  // The extra bit on each side catches the last bit shifted out; a zero
  // count leaves that bit 0, which gives carry 0 for free.
  assign shl = {1'b0, a} << cnt;
  assign shr = {a, 1'b0} >> cnt;
  assign rol = {a, a} << cnt;
  assign ror = {a, a} >> cnt;

  always_comb begin
    sum   = '0;
    res   = '0;
    carry = 1'b0;
    case (op)
      ALU_ADD:  sum = {1'b0, a} + {1'b0, b};
      ALU_ADDC: sum = {1'b0, a} + {1'b0, b} + (DW+1)'(cin);
      ALU_SUB:  sum = {1'b0, a} - {1'b0, b};
      ALU_SUBC: sum = {1'b0, a} - {1'b0, b} - (DW+1)'(cin);
      default:  sum = '0;
    endcase
    case (op)
      ALU_ADD, ALU_ADDC, ALU_SUB, ALU_SUBC: begin
        res   = sum[DW-1:0];
        carry = sum[DW];  // borrow for subtracts
      end
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_MASK: res = a & ~b;
      ALU_SHL: begin
        res   = shl[DW-1:0];
        carry = shl[DW];
      end
      ALU_SHR: begin
        res   = shr[DW:1];
        carry = shr[0];
      end
      ALU_ROL:  res = rol[2*DW-1:DW];
      ALU_ROR:  res = ror[DW-1:0];
      default:  res = '0;
    endcase
  end

  assign zero = (res == '0);

endmodule

// File: rtl/gumnut_datapath_gen.sv
// Parametrised Gumnut execution datapath: register file (2 async reads,
// 1 sync write, r0 hard-wired to 0), ALU, result register, carry/zero flags
// with interrupt shadow, and a handshaked port-output register.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : gumnut_datapath_gen_if.slave (decoded fields, strobes,
//                  read data in; rs2/ALU result, flags, port traffic out)
// Optional build macro GUMNUT_FWD_EN: register reads of the index being
// written this cycle return the writeback value (write-through). Without it
// reads return the pre-write contents.
module gumnut_datapath_gen
  import gumnut_dp_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  gumnut_datapath_gen_if.slave bus
);

  localparam int RAW = $clog2(NREG);
  localparam int CW  = $clog2(DW);

  logic [NREG-1:0][DW-1:0] regs;
  logic [DW-1:0]           wb_val;
  logic [DW-1:0]           rs_val, rs2_val;
  logic [DW-1:0]           op2_val;
  logic [DW-1:0]           alu_res;
  logic                    alu_c, alu_z;
  logic [DW-1:0]           res_q;
  logic                    carry_q, zero_q, carry_sh, zero_sh;
  port_st_t                pst;
  logic [DW-1:0]           padr_q, pdat_q;
  logic                    stb_q, busy_q;
  logic                    wr_en;

  assign wr_en = bus.clk_en_i & bus.reg_wr_c & (bus.rd_sel_i != '0);

  always_comb begin
    wb_val = '0;
    case (wb_sel_t'(bus.reg_mux_c))
      WB_RES:  wb_val = res_q;
      WB_DATA: wb_val = bus.data_dat_i;
      WB_PORT: wb_val = bus.port_dat_i;
      default: wb_val = '0;
    endcase
  end

  always_comb begin
    rs_val  = (bus.rs_sel_i  == '0) ? '0 : regs[bus.rs_sel_i];
    rs2_val = (bus.rs2_sel_i == '0) ? '0 : regs[bus.rs2_sel_i];
`ifdef GUMNUT_FWD_EN
    if (wr_en && bus.rs_sel_i  == bus.rd_sel_i) rs_val  = wb_val;
    if (wr_en && bus.rs2_sel_i == bus.rd_sel_i) rs2_val = wb_val;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      regs <= '0;
    else if (wr_en) regs[bus.rd_sel_i] <= wb_val;
  end

  assign op2_val = bus.op2_c ? rs2_val : DW'(bus.immed_i);

  gumnut_alu_gen #(.DW(DW), .CW(CW)) u_alu (
    .a     (rs_val),
    .b     (op2_val),
    .cnt   (bus.count_i),
    .op    (alu_op_t'(bus.alu_op_c)),
    .cin   (carry_q),
    .res   (alu_res),
    .carry (alu_c),
    .zero  (alu_z)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                           res_q <= '0;
    else if (bus.clk_en_i && bus.alu_en_c) res_q <= alu_res;
  end

  // Shadow samples pre-edge flags, so save+update in one cycle keeps the
  // old flags; restore takes priority over an ALU flag load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      carry_sh <= 1'b0;
      zero_sh  <= 1'b0;
    end else if (bus.clk_en_i) begin
      if (bus.int_save_c) begin
        carry_sh <= carry_q;
        zero_sh  <= zero_q;
      end
      if (bus.int_rest_c) begin
        carry_q <= carry_sh;
        zero_q  <= zero_sh;
      end else if (bus.alu_fr_c) begin
        carry_q <= alu_c;
        zero_q  <= alu_z;
      end
    end
  end

  // Port write handshake. A new request while one is pending is dropped
  // (busy pulse) unless the target acks this cycle, which frees the slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pst    <= P_IDLE;
      padr_q <= '0;
      pdat_q <= '0;
      stb_q  <= 1'b0;
      busy_q <= 1'b0;
    end else if (bus.clk_en_i) begin
      busy_q <= 1'b0;
      case (pst)
        P_IDLE: if (bus.port_we_c) begin
          padr_q <= alu_res;
          pdat_q <= rs2_val;
          pst    <= P_PEND;
          stb_q  <= 1'b1;
        end
        P_PEND: begin
          if (bus.port_ack_i) begin
            if (bus.port_we_c) begin
              padr_q <= alu_res;
              pdat_q <= rs2_val;
            end else begin
              pst   <= P_IDLE;
              stb_q <= 1'b0;
            end
          end else if (bus.port_we_c) begin
            busy_q <= 1'b1;
          end
        end
        default: pst <= P_IDLE;
      endcase
    end
  end

  assign bus.rs2_o       = rs2_val;
  assign bus.alu_res_o   = alu_res;
  assign bus.carry_o     = carry_q;
  assign bus.zero_o      = zero_q;
  assign bus.port_adr_o  = padr_q;
  assign bus.port_dat_o  = pdat_q;
  assign bus.port_stb_o  = stb_q;
  assign bus.port_busy_o = busy_q;

endmodule

// File: tb/tb_gumnut_datapath_gen.sv
// Directed bench for gumnut_datapath_gen: an 8-bit/8-register instance (ua)
// and a 16-bit/16-register instance (ub) sharing clock and reset.
module tb_gumnut_datapath_gen;
  import gumnut_dp_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_i = ~clk_i;

  gumnut_datapath_gen_if #(.DW(8),  .NREG(8))  ifa ();
  gumnut_datapath_gen_if #(.DW(16), .NREG(16)) ifb ();

  gumnut_datapath_gen #(.DW(8),  .NREG(8))  ua (.clk_i(clk_i), .rst_i(rst_i), .bus(ifa));
  gumnut_datapath_gen #(.DW(16), .NREG(16)) ub (.clk_i(clk_i), .rst_i(rst_i), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_a();
    ifa.clk_en_i = 1'b1;  ifa.rs_sel_i = '0;   ifa.rs2_sel_i = '0;
    ifa.rd_sel_i = '0;    ifa.immed_i = '0;    ifa.count_i = '0;
    ifa.alu_op_c = ALU_ADD; ifa.op2_c = 1'b0;  ifa.alu_en_c = 1'b0;
    ifa.alu_fr_c = 1'b0;  ifa.reg_wr_c = 1'b0; ifa.reg_mux_c = 2'b00;
    ifa.data_dat_i = '0;  ifa.port_dat_i = '0; ifa.int_save_c = 1'b0;
    ifa.int_rest_c = 1'b0; ifa.port_we_c = 1'b0; ifa.port_ack_i = 1'b0;
  endtask

  task automatic idle_b();
    ifb.clk_en_i = 1'b1;  ifb.rs_sel_i = '0;   ifb.rs2_sel_i = '0;
    ifb.rd_sel_i = '0;    ifb.immed_i = '0;    ifb.count_i = '0;
    ifb.alu_op_c = ALU_ADD; ifb.op2_c = 1'b0;  ifb.alu_en_c = 1'b0;
    ifb.alu_fr_c = 1'b0;  ifb.reg_wr_c = 1'b0; ifb.reg_mux_c = 2'b00;
    ifb.data_dat_i = '0;  ifb.port_dat_i = '0; ifb.int_save_c = 1'b0;
    ifb.int_rest_c = 1'b0; ifb.port_we_c = 1'b0; ifb.port_ack_i = 1'b0;
  endtask

  // load a register of ua from data_dat_i
  task automatic wr_a(input logic [2:0] idx, input logic [7:0] val);
    idle_a();
    ifa.reg_wr_c = 1'b1; ifa.reg_mux_c = 2'b01;
    ifa.rd_sel_i = idx;  ifa.data_dat_i = val;
    tick();
    idle_a();
  endtask

  // set up an ALU op on ua (comb result visible after #1)
  task automatic op_a(input alu_op_t op, input logic [2:0] rs, input logic [2:0] rs2,
                      input logic op2, input logic [7:0] imm, input logic [2:0] cnt);
    idle_a();
    ifa.alu_op_c = op; ifa.rs_sel_i = rs; ifa.rs2_sel_i = rs2;
    ifa.op2_c = op2;   ifa.immed_i = imm; ifa.count_i = cnt;
    #1;
  endtask

  initial begin
    idle_a();
    idle_b();
    #3;
    chk("rst_stb",   {31'd0, ifa.port_stb_o}, 32'd0);
    chk("rst_carry", {31'd0, ifa.carry_o},    32'd0);
    chk("rst_adr",   {24'd0, ifa.port_adr_o}, 32'd0);
    ifa.rs2_sel_i = 3'd1; #1;
    chk("rst_r1",    {24'd0, ifa.rs2_o},      32'd0);
    #8 rst_i = 1'b0;
    tick();

    // 1: ADD 0xF0 + 0x20 -> 0x10, carry 1, writeback to r3
    wr_a(3'd1, 8'hF0);
    wr_a(3'd2, 8'h20);
    op_a(ALU_ADD, 3'd1, 3'd2, 1'b1, 8'h00, 3'd0);
    chk("add_res", {24'd0, ifa.alu_res_o}, 32'h10);
    ifa.alu_en_c = 1'b1; ifa.alu_fr_c = 1'b1; ifa.rd_sel_i = 3'd3;
    tick();
    chk("add_c", {31'd0, ifa.carry_o}, 32'd1);
    chk("add_z", {31'd0, ifa.zero_o},  32'd0);
    idle_a();
    ifa.reg_wr_c = 1'b1; ifa.reg_mux_c = 2'b00; ifa.rd_sel_i = 3'd3;
    tick();
    idle_a(); ifa.rs2_sel_i = 3'd3; #1;
    chk("wb_r3", {24'd0, ifa.rs2_o}, 32'h10);

    // 2: SUB 5-5 -> zero; SUB 3-5 -> 0xFE with borrow
    wr_a(3'd1, 8'h05);
    wr_a(3'd2, 8'h05);
    op_a(ALU_SUB, 3'd1, 3'd2, 1'b1, 8'h00, 3'd0);
    ifa.alu_fr_c = 1'b1; tick();
    chk("sub0_z", {31'd0, ifa.zero_o},  32'd1);
    chk("sub0_c", {31'd0, ifa.carry_o}, 32'd0);
    wr_a(3'd5, 8'h03);
    op_a(ALU_SUB, 3'd5, 3'd0, 1'b0, 8'h05, 3'd0);
    chk("sub_res", {24'd0, ifa.alu_res_o}, 32'hFE);
    ifa.alu_fr_c = 1'b1; tick();
    chk("sub_c", {31'd0, ifa.carry_o}, 32'd1);
    // SUBC 3 - 0 - carry(1) = 2, no borrow
    op_a(ALU_SUBC, 3'd5, 3'd0, 1'b0, 8'h00, 3'd0);
    chk("subc_res", {24'd0, ifa.alu_res_o}, 32'h02);

    // 3: shadow save/restore, restore beats alu_fr_c (flags now c=1 z=0)
    idle_a(); ifa.int_save_c = 1'b1; tick();
    op_a(ALU_SUB, 3'd1, 3'd2, 1'b1, 8'h00, 3'd0);
    ifa.alu_fr_c = 1'b1; tick();
    chk("isr_cz", {30'd0, ifa.carry_o, ifa.zero_o}, 32'b01);
    idle_a(); ifa.int_rest_c = 1'b1; tick();
    chk("rest_cz", {30'd0, ifa.carry_o, ifa.zero_o}, 32'b10);
    op_a(ALU_SUB, 3'd1, 3'd2, 1'b1, 8'h00, 3'd0);
    ifa.alu_fr_c = 1'b1; tick();
    op_a(ALU_SUB, 3'd1, 3'd2, 1'b1, 8'h00, 3'd0);
    ifa.alu_fr_c = 1'b1; ifa.int_rest_c = 1'b1; tick();
    chk("rest_prio", {30'd0, ifa.carry_o, ifa.zero_o}, 32'b10);

    // 4: port write held 3 cycles, second request dropped
    wr_a(3'd6, 8'h5A);
    op_a(ALU_ADD, 3'd0, 3'd6, 1'b0, 8'h40, 3'd0);
    ifa.port_we_c = 1'b1; tick();
    chk("p_stb1", {31'd0, ifa.port_stb_o}, 32'd1);
    chk("p_adr1", {24'd0, ifa.port_adr_o}, 32'h40);
    chk("p_dat1", {24'd0, ifa.port_dat_o}, 32'h5A);
    op_a(ALU_ADD, 3'd0, 3'd1, 1'b0, 8'h41, 3'd0);
    ifa.port_we_c = 1'b1; tick();
    chk("p_busy", {31'd0, ifa.port_busy_o}, 32'd1);
    chk("p_adr2", {24'd0, ifa.port_adr_o}, 32'h40);
    chk("p_dat2", {24'd0, ifa.port_dat_o}, 32'h5A);
    idle_a(); tick();
    chk("p_busy0", {31'd0, ifa.port_busy_o}, 32'd0);
    chk("p_stb3",  {31'd0, ifa.port_stb_o},  32'd1);
    ifa.port_ack_i = 1'b1; tick();
    chk("p_ack", {31'd0, ifa.port_stb_o}, 32'd0);
    // back-to-back: ack with a new request reloads and stays pending
    op_a(ALU_ADD, 3'd0, 3'd6, 1'b0, 8'h10, 3'd0);
    ifa.port_we_c = 1'b1; tick();
    op_a(ALU_ADD, 3'd0, 3'd6, 1'b0, 8'h20, 3'd0);
    ifa.port_we_c = 1'b1; ifa.port_ack_i = 1'b1; tick();
    chk("b2b_stb", {31'd0, ifa.port_stb_o}, 32'd1);
    chk("b2b_adr", {24'd0, ifa.port_adr_o}, 32'h20);
    idle_a(); ifa.port_ack_i = 1'b1; tick();
    chk("b2b_end", {31'd0, ifa.port_stb_o}, 32'd0);

    // logic ops and shifts
    op_a(ALU_AND,  3'd6, 3'd0, 1'b0, 8'h3C, 3'd0);
    chk("and",  {24'd0, ifa.alu_res_o}, 32'h18);
    op_a(ALU_MASK, 3'd6, 3'd0, 1'b0, 8'h3C, 3'd0);
    chk("mask", {24'd0, ifa.alu_res_o}, 32'h42);
    wr_a(3'd7, 8'h81);
    op_a(ALU_SHL, 3'd7, 3'd0, 1'b0, 8'h00, 3'd1);
    chk("shl", {24'd0, ifa.alu_res_o}, 32'h02);
    ifa.alu_fr_c = 1'b1; tick();
    chk("shl_c", {31'd0, ifa.carry_o}, 32'd1);
    op_a(ALU_SHR, 3'd7, 3'd0, 1'b0, 8'h00, 3'd1);
    chk("shr", {24'd0, ifa.alu_res_o}, 32'h40);
    op_a(ALU_ROL, 3'd7, 3'd0, 1'b0, 8'h00, 3'd1);
    chk("rol", {24'd0, ifa.alu_res_o}, 32'h03);
    ifa.alu_fr_c = 1'b1; tick();
    chk("rol_c", {31'd0, ifa.carry_o}, 32'd0);
    op_a(ALU_ROR, 3'd7, 3'd0, 1'b0, 8'h00, 3'd1);
    chk("ror", {24'd0, ifa.alu_res_o}, 32'hC0);
    op_a(ALU_SHL, 3'd6, 3'd0, 1'b0, 8'h00, 3'd0);
    ifa.alu_fr_c = 1'b1; #1;
    chk("shl0", {24'd0, ifa.alu_res_o}, 32'h5A);
    op_a(ALU_SHR, 3'd7, 3'd0, 1'b0, 8'h00, 3'd0);
    ifa.alu_fr_c = 1'b1; tick();
    chk("shr0_c", {31'd0, ifa.carry_o}, 32'd0);

    // clock enable low blocks register writes
    idle_a();
    ifa.clk_en_i = 1'b0; ifa.reg_wr_c = 1'b1; ifa.reg_mux_c = 2'b01;
    ifa.rd_sel_i = 3'd1; ifa.data_dat_i = 8'h77;
    tick();
    idle_a(); ifa.rs2_sel_i = 3'd1; #1;
    chk("clken", {24'd0, ifa.rs2_o}, 32'h05);

    // 5: r0 ignores writes; 16-bit wrap
    wr_a(3'd0, 8'hFF);
    op_a(ALU_ADD, 3'd0, 3'd0, 1'b1, 8'h00, 3'd0);
    chk("r0_rd", {24'd0, ifa.rs2_o},     32'd0);
    chk("r0_alu", {24'd0, ifa.alu_res_o}, 32'd0);
    ifb.reg_wr_c = 1'b1; ifb.reg_mux_c = 2'b01; ifb.rd_sel_i = 4'd15;
    ifb.data_dat_i = 16'hFFFF;
    tick();
    idle_b();
    ifb.alu_op_c = ALU_ADD; ifb.rs_sel_i = 4'd15; ifb.immed_i = 8'h01;
    ifb.alu_fr_c = 1'b1; #1;
    chk("w16_res", {16'd0, ifb.alu_res_o}, 32'd0);
    tick();
    chk("w16_c", {31'd0, ifb.carry_o}, 32'd1);
    chk("w16_z", {31'd0, ifb.zero_o},  32'd1);
    idle_b();

    // 6: write-through read of r4 in the write cycle
    idle_a();
    ifa.reg_wr_c = 1'b1; ifa.reg_mux_c = 2'b01; ifa.rd_sel_i = 3'd4;
    ifa.data_dat_i = 8'h33; ifa.rs2_sel_i = 3'd4; #1;
`ifdef GUMNUT_FWD_EN
    chk("fwd", {24'd0, ifa.rs2_o}, 32'h33);
`else
    chk("fwd", {24'd0, ifa.rs2_o}, 32'h00);
`endif
    tick();
    idle_a(); ifa.rs2_sel_i = 3'd4; #1;
    chk("r4", {24'd0, ifa.rs2_o}, 32'h33);

    // reset during a pending write drops stb without a clock edge
    op_a(ALU_ADD, 3'd0, 3'd6, 1'b0, 8'h40, 3'd0);
    ifa.port_we_c = 1'b1; tick();
    idle_a();
    chk("pend", {31'd0, ifa.port_stb_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_async", {31'd0, ifa.port_stb_o}, 32'd0);
    #1 rst_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
